bus_arbiter: RTL and testbench
==============================

// Module: bus_arbiter
// PURPOSE
// Two-requester round-robin arbiter for the Manta internal register bus (addr/wdata/rw/valid -> rdata).
// Lets two host bridges (e.g. Ethernet RX and UART) share one core chain (LUT memory, IO, logic analyzer).
// Tracks in-flight reads and routes each bus response back to its originator.
// Flags responses that arrive unexpected or never arrive.
// PARAMETERS
// ADDR_WIDTH    16  bus address width
// DATA_WIDTH    16  bus data width
// RESP_LATENCY  4   cycles from bus_valid (read) to the matching bus_rdata_valid; must be >= 1
// PORTS
// clk              in   1           bus clock (50 MHz in Ethernet builds)
// rst              in   1           asynchronous, active-high reset
// a_addr/b_addr    in   ADDR_WIDTH  requester address
// a_wdata/b_wdata  in   DATA_WIDTH  requester write data
// a_rw/b_rw        in   1           1 = write, 0 = read
// a_valid/b_valid  in   1           request valid; held stable until accepted
// a_ready/b_ready  out  1           request accepted this cycle (combinational grant)
// a_rdata/b_rdata  out  DATA_WIDTH  routed read data
// a_rvalid/b_rvalid out 1           one-cycle pulse, read data valid
// bus_addr, bus_wdata, bus_rw, bus_valid  out  ADDR/DATA/1/1  registered request to core chain
// bus_rdata        in   DATA_WIDTH  read data returned from end of core chain
// bus_rdata_valid  in   1           read data valid
// resp_orphan      out  1           sticky: response arrived with no read in flight
// resp_lost        out  1           sticky: expected response did not arrive
// BEHAVIOUR
// - Reset: all outputs 0; tag line cleared; rr pointer = A; both sticky flags cleared.
// - Grant is combinational:
//   - only one valid -> grant it;
//   - both valid -> grant the side other than last_grant.
//   - last_grant updates only on an accepted transfer (valid & ready).
// - Acceptance at edge N:
//   - bus_* drives the transaction during cycle N+1 with bus_valid = 1;
//   - otherwise bus_valid = 0 and bus_addr/wdata/rw hold their last value.
// - Throughput: one transaction per cycle. Back-to-back A,B,A,B under continuous contention.
// - Writes: no response expected, nothing is pushed to the tag line.
// - Tag line: RESP_LATENCY-deep shift of {pending, id}, shifted every cycle.
//   - Entered as {~bus_rw & bus_valid, id} in the cycle bus_valid is high.
//   - The tail entry aligns with the cycle its bus_rdata_valid is due.
// - Response routing, at the tail:
//   - bus_rdata_valid & pending -> <id>_rdata <= bus_rdata and <id>_rvalid pulses the next cycle.
//   - The other requester's rvalid stays 0.
//   - Total read latency: accept edge to rvalid = RESP_LATENCY + 2 cycles.
// - rdata holds its value between pulses.
// - Error flags:
//   - bus_rdata_valid & !pending -> resp_orphan = 1 (response dropped);
//   - pending & !bus_rdata_valid -> resp_lost = 1.
//   - Both flags are sticky until rst.
// - Reset mid-operation:
//   - clears all pending tags; in-flight responses are dropped silently.
//   - A post-reset guard counter suppresses resp_orphan for RESP_LATENCY cycles after rst deasserts.
// - Simultaneous events in one cycle are all independent:
//   - an accept, a tail response and a tag shift;
//   - an A read returning while B's request is issued.
// - A requester deasserting valid without ready is a protocol violation; behaviour is undefined, not checked.
// STRUCTURE
// - Shared package manta_bus_pkg:
//   - typedef bus_req_t {addr, wdata, rw};
//   - enum req_id_t {REQ_A, REQ_B};
//   - shared ADDR_WIDTH/DATA_WIDTH defaults.
// - Sub-module tag_delay_line:
//   - parameterised-depth shift register of {pending, req_id_t} with async reset;
//   - exposes the tail entry.
// - Top level holds grant logic, rr state, output register, response router, error flags and guard counter.
// TESTING
// 1. Only A reads addr 0x0003, RESP_LATENCY=4, model returns 0xBEEF
//    -> bus_valid 1 cycle after accept, a_rvalid 6 cycles after accept with 0xBEEF, b_rvalid stays 0.
// 2. A and B valid continuously (A reads, B writes 0x1234 to 0x0010) for 8 cycles
//    -> grants alternate B,A,B,A... (last_grant=A after reset);
//    -> 4 A responses routed; no b_rvalid.
// 3. A read issued, then B read next cycle, model returns 0x1111 then 0x2222
//    -> a_rvalid with 0x1111, b_rvalid one cycle later with 0x2222.
// 4. Inject bus_rdata_valid with no read outstanding -> resp_orphan = 1 next cycle and stays 1; no rvalid pulses.
// 5. Issue a read, suppress its response -> resp_lost = 1 at the due cycle + 1.
// 6. Assert rst 2 cycles after a read accept, model still returns data
//    -> no rvalid, resp_orphan stays 0; a new A read after reset completes normally.

Source files
------------

// File: rtl/manta_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : manta_bus_pkg
//  Description : Shared types and defaults for the Manta register-bus
//                arbiter (request bundle, requester id, tag-line entry).
//  Revision    : 1.0 - initial release
// ============================================================================
package manta_bus_pkg;

    localparam int unsigned c_ADDR_WIDTH = 16;
    localparam int unsigned c_DATA_WIDTH = 16;

    // Requester identity; REQ_A is the round-robin pointer value after reset.
    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_t;

    // One request as presented on the core-chain bus.
    typedef struct packed {
        logic [c_ADDR_WIDTH-1:0] addr;
        logic [c_DATA_WIDTH-1:0] wdata;
        logic                    rw;
    } bus_req_t;

    // One slot of the in-flight read tracker.
    typedef struct packed {
        logic    pending;
        req_id_t id;
    } tag_t;

    // The requester that did not win last time.
    function automatic req_id_t other_id(input req_id_t id);
        return (id == REQ_A) ? REQ_B : REQ_A;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bus_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : bus_arbiter_if
//  Description : Signal bundle around the arbiter: two requester ports, the
//                core-chain bus and the sticky error flags.
//                master = requesters + core chain, slave = arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface bus_arbiter_if
    import manta_bus_pkg::*;
#(
    parameter int ADDR_WIDTH = c_ADDR_WIDTH,
    parameter int DATA_WIDTH = c_DATA_WIDTH
);

    // Requester A
    logic [ADDR_WIDTH-1:0] a_addr;
    logic [DATA_WIDTH-1:0] a_wdata;
    logic                  a_rw;
    logic                  a_valid;
    logic                  a_ready;
    logic [DATA_WIDTH-1:0] a_rdata;
    logic                  a_rvalid;

    // Requester B
    logic [ADDR_WIDTH-1:0] b_addr;
    logic [DATA_WIDTH-1:0] b_wdata;
    logic                  b_rw;
    logic                  b_valid;
    logic                  b_ready;
    logic [DATA_WIDTH-1:0] b_rdata;
    logic                  b_rvalid;

    // Core chain
    logic [ADDR_WIDTH-1:0] bus_addr;
    logic [DATA_WIDTH-1:0] bus_wdata;
    logic                  bus_rw;
    logic                  bus_valid;
    logic [DATA_WIDTH-1:0] bus_rdata;
    logic                  bus_rdata_valid;

    // Error flags
    logic                  resp_orphan;
    logic                  resp_lost;

    modport master (
        output a_addr, a_wdata, a_rw, a_valid,
        input  a_ready, a_rdata, a_rvalid,
        output b_addr, b_wdata, b_rw, b_valid,
        input  b_ready, b_rdata, b_rvalid,
        input  bus_addr, bus_wdata, bus_rw, bus_valid,
        output bus_rdata, bus_rdata_valid,
        input  resp_orphan, resp_lost
    );

    modport slave (
        input  a_addr, a_wdata, a_rw, a_valid,
        output a_ready, a_rdata, a_rvalid,
        input  b_addr, b_wdata, b_rw, b_valid,
        output b_ready, b_rdata, b_rvalid,
        output bus_addr, bus_wdata, bus_rw, bus_valid,
        input  bus_rdata, bus_rdata_valid,
        output resp_orphan, resp_lost
    );

endinterface
`default_nettype wire

// File: rtl/tag_delay_line.sv
`default_nettype none
// ============================================================================
//  Module      : tag_delay_line
//  Description : DEPTH-stage shift register of {pending, id} tags, shifted
//                every cycle; the last stage is exposed as the tail.
//  Revision    : 1.0 - initial release
// ============================================================================
module tag_delay_line
    import manta_bus_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire tag_t i_tag,
    output tag_t      o_tail
);

    tag_t r_tag [DEPTH];

    // Shift one stage per cycle; reset drops every in-flight tag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_tag[k] <= '0;
            end
        end else begin
            for (int k = DEPTH - 1; k > 0; k--) begin
                r_tag[k] <= r_tag[k-1];
            end
            r_tag[0] <= i_tag;
        end
    end

    assign o_tail = r_tag[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : bus_arbiter
//  Description : Two-requester round-robin arbiter for the Manta register
//                bus. Registers the granted request onto the core chain,
//                tracks reads in flight and routes each response back to its
//                originator; flags orphan and lost responses.
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_arbiter
    import manta_bus_pkg::*;
#(
    parameter int ADDR_WIDTH   = c_ADDR_WIDTH,
    parameter int DATA_WIDTH   = c_DATA_WIDTH,
    parameter int RESP_LATENCY = 4
) (
    input  wire logic     clk,
    input  wire logic     rst,
    bus_arbiter_if.slave  io
);

    localparam int              c_GUARD_W    = $clog2(RESP_LATENCY + 1);
    localparam [c_GUARD_W-1:0]  c_GUARD_INIT = c_GUARD_W'(RESP_LATENCY);

    logic                  w_grant_a;
    logic                  w_grant_b;
    logic                  w_accept;
    req_id_t               w_grant_id;

    req_id_t               r_last_grant;

    logic [ADDR_WIDTH-1:0] r_bus_addr;
    logic [DATA_WIDTH-1:0] r_bus_wdata;
    logic                  r_bus_rw;
    logic                  r_bus_valid;
    req_id_t               r_bus_id;

    tag_t                  w_tag_in;
    tag_t                  w_tail;

    logic                  r_a_rvalid;
    logic                  r_b_rvalid;
    logic [DATA_WIDTH-1:0] r_a_rdata;
    logic [DATA_WIDTH-1:0] r_b_rdata;

    logic                  r_orphan;
    logic                  r_lost;
    logic [c_GUARD_W-1:0]  r_guard;

    // Combinational grant: a lone request wins, a tie goes to the side that did not win last.
    always_comb begin
        w_grant_a = 1'b0;
        w_grant_b = 1'b0;
        if (!rst) begin
            if (io.a_valid && io.b_valid) begin
                if (other_id(r_last_grant) == REQ_A) begin
                    w_grant_a = 1'b1;
                end else begin
                    w_grant_b = 1'b1;
                end
            end else begin
                w_grant_a = io.a_valid;
                w_grant_b = io.b_valid;
            end
        end
    end

    assign w_accept   = w_grant_a | w_grant_b;
    assign w_grant_id = w_grant_b ? REQ_B : REQ_A;

    // Round-robin pointer moves only on an accepted transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant <= REQ_A;
        end else if (w_accept) begin
            r_last_grant <= w_grant_id;
        end
    end

    // Launch the granted request next cycle; address/data hold when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_bus_rw    <= 1'b0;
            r_bus_valid <= 1'b0;
            r_bus_id    <= REQ_A;
        end else begin
            r_bus_valid <= w_accept;
            if (w_accept) begin
                r_bus_addr  <= w_grant_b ? io.b_addr  : io.a_addr;
                r_bus_wdata <= w_grant_b ? io.b_wdata : io.a_wdata;
                r_bus_rw    <= w_grant_b ? io.b_rw    : io.a_rw;
                r_bus_id    <= w_grant_id;
            end
        end
    end

    // Only reads on the bus create a pending tag; writes enter as empty slots.
    assign w_tag_in = '{pending: r_bus_valid & ~r_bus_rw, id: r_bus_id};

    tag_delay_line #(
        .DEPTH (RESP_LATENCY)
    ) u_tag_line (
        .clk    (clk),
        .rst    (rst),
        .i_tag  (w_tag_in),
        .o_tail (w_tail)
    );

    // Route a response that lines up with a pending tail entry to its owner.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_rvalid <= 1'b0;
            r_b_rvalid <= 1'b0;
            r_a_rdata  <= '0;
            r_b_rdata  <= '0;
        end else begin
            r_a_rvalid <= 1'b0;
            r_b_rvalid <= 1'b0;
            if (io.bus_rdata_valid && w_tail.pending) begin
                if (w_tail.id == REQ_A) begin
                    r_a_rvalid <= 1'b1;
                    r_a_rdata  <= io.bus_rdata;
                end else begin
                    r_b_rvalid <= 1'b1;
                    r_b_rdata  <= io.bus_rdata;
                end
            end
        end
    end

    // Counts down after reset so responses to reads issued before reset are dropped quietly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_guard <= c_GUARD_INIT;
        end else if (r_guard != '0) begin
            r_guard <= r_guard - 1'b1;
        end
    end

    // Sticky error flags: unexpected response, or missing response at the due slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_orphan <= 1'b0;
            r_lost   <= 1'b0;
        end else begin
            if (io.bus_rdata_valid && !w_tail.pending && (r_guard == '0)) begin
                r_orphan <= 1'b1;
            end
            if (w_tail.pending && !io.bus_rdata_valid) begin
                r_lost <= 1'b1;
            end
        end
    end

    assign io.a_ready     = w_grant_a;
    assign io.b_ready     = w_grant_b;
    assign io.a_rdata     = r_a_rdata;
    assign io.a_rvalid    = r_a_rvalid;
    assign io.b_rdata     = r_b_rdata;
    assign io.b_rvalid    = r_b_rvalid;
    assign io.bus_addr    = r_bus_addr;
    assign io.bus_wdata   = r_bus_wdata;
    assign io.bus_rw      = r_bus_rw;
    assign io.bus_valid   = r_bus_valid;
    assign io.resp_orphan = r_orphan;
    assign io.resp_lost   = r_lost;

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_bus_arbiter
//  Description : Self-checking bench for bus_arbiter: directed scenarios plus
//                a randomized phase against a cycle-indexed reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter;
    import manta_bus_pkg::*;

    localparam int c_L    = 4;
    localparam int c_MAXC = 1024;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bus_arbiter_if io ();

    bus_arbiter #(
        .ADDR_WIDTH   (16),
        .DATA_WIDTH   (16),
        .RESP_LATENCY (c_L)
    ) dut (
        .clk (clk),
        .rst (rst),
        .io  (io)
    );

    int n_asrt = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Reference model state: everything indexed by absolute cycle number.
    bit          m_last;              // 0 = A won last, 1 = B won last
    logic        m_bus_valid;
    logic [15:0] m_bus_addr;
    logic [15:0] m_bus_wdata;
    logic        m_bus_rw;
    bit          due_v   [c_MAXC];    // a read response is due in this cycle
    bit          due_id  [c_MAXC];
    logic [15:0] due_data[c_MAXC];
    bit          ep_a    [c_MAXC];    // expected rvalid pulse in this cycle
    bit          ep_b    [c_MAXC];
    logic [15:0] ed      [c_MAXC];
    logic [15:0] m_a_rdata;
    logic [15:0] m_b_rdata;
    bit          m_orphan;
    bit          m_lost;
    int          guard_end;

    // Core-chain model: memory plus a queue of scheduled responses.
    logic [15:0] mem [256];
    typedef struct {
        int          due;
        logic [15:0] data;
    } core_t;
    core_t coreq[$];
    bit    drop_next = 1'b0;
    bit    inject    = 1'b0;
    int    cnt_arv   = 0;
    int    cnt_brv   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < c_MAXC; i++) begin
            due_v[i] = 1'b0;
            ep_a[i]  = 1'b0;
            ep_b[i]  = 1'b0;
        end
        m_last      = 1'b0;
        m_bus_valid = 1'b0;
        m_bus_addr  = '0;
        m_bus_wdata = '0;
        m_bus_rw    = 1'b0;
        m_a_rdata   = '0;
        m_b_rdata   = '0;
        m_orphan    = 1'b0;
        m_lost      = 1'b0;
    endtask

    task automatic req_a(input logic rw, input logic [15:0] addr, input logic [15:0] wdata);
        io.a_valid = 1'b1; io.a_rw = rw; io.a_addr = addr; io.a_wdata = wdata;
    endtask

    task automatic req_b(input logic rw, input logic [15:0] addr, input logic [15:0] wdata);
        io.b_valid = 1'b1; io.b_rw = rw; io.b_addr = addr; io.b_wdata = wdata;
    endtask

    // One clock cycle: check outputs, advance the model, play the core chain.
    task automatic tick();
        bit          ga;
        bit          gb;
        bit          drv;
        logic [15:0] drv_data;
        int          c;
        #1;
        c = cyc;
        chk("bus_valid", io.bus_valid, m_bus_valid);
        chk("bus_addr",  io.bus_addr,  m_bus_addr);
        chk("bus_wdata", io.bus_wdata, m_bus_wdata);
        chk("bus_rw",    io.bus_rw,    m_bus_rw);
        if (ep_a[c]) m_a_rdata = ed[c];
        if (ep_b[c]) m_b_rdata = ed[c];
        chk("a_rvalid",    io.a_rvalid,    ep_a[c]);
        chk("b_rvalid",    io.b_rvalid,    ep_b[c]);
        chk("a_rdata",     io.a_rdata,     m_a_rdata);
        chk("b_rdata",     io.b_rdata,     m_b_rdata);
        chk("resp_orphan", io.resp_orphan, m_orphan);
        chk("resp_lost",   io.resp_lost,   m_lost);
        if (io.a_rvalid) cnt_arv++;
        if (io.b_rvalid) cnt_brv++;

        // Fairness rule: lone requester wins; on a tie the loser of last time wins.
        ga = 1'b0;
        gb = 1'b0;
        if (!rst) begin
            if (io.a_valid && io.b_valid) begin
                ga = m_last;
                gb = !m_last;
            end else begin
                ga = io.a_valid;
                gb = io.b_valid;
            end
        end
        chk("a_ready", io.a_ready, ga);
        chk("b_ready", io.b_ready, gb);
        m_bus_valid = ga | gb;
        if (ga | gb) begin
            m_bus_addr  = ga ? io.a_addr  : io.b_addr;
            m_bus_wdata = ga ? io.a_wdata : io.b_wdata;
            m_bus_rw    = ga ? io.a_rw    : io.b_rw;
            m_last      = gb;
            if (!m_bus_rw) begin
                due_v[c + 1 + c_L]    = 1'b1;
                due_id[c + 1 + c_L]   = gb;
                due_data[c + 1 + c_L] = mem[m_bus_addr[7:0]];
            end
        end

        // Core chain answers every read RESP_LATENCY cycles after it sees it.
        if (io.bus_valid && !io.bus_rw)
            coreq.push_back(core_t'{due: c + c_L, data: mem[io.bus_addr[7:0]]});
        drv      = 1'b0;
        drv_data = 16'($urandom);
        if (coreq.size() > 0 && coreq[0].due == c) begin
            if (drop_next) begin
                drop_next = 1'b0;
            end else begin
                drv      = 1'b1;
                drv_data = coreq[0].data;
            end
            void'(coreq.pop_front());
        end
        if (inject) begin
            drv      = 1'b1;
            drv_data = 16'hDEAD;
            inject   = 1'b0;
        end
        io.bus_rdata_valid = drv;
        io.bus_rdata       = drv_data;

        // Expected consequences of this cycle's bus response, visible next cycle.
        if (!rst) begin
            if (drv && due_v[c]) begin
                if (due_id[c]) ep_b[c + 1] = 1'b1;
                else           ep_a[c + 1] = 1'b1;
                ed[c + 1] = due_data[c];
            end
            if (drv && !due_v[c] && c >= guard_end) m_orphan = 1'b1;
            if (due_v[c] && !drv)                   m_lost   = 1'b1;
        end

        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (ga) io.a_valid = 1'b0;
        if (gb) io.b_valid = 1'b0;
    endtask

    task automatic do_reset(input int n);
        rst        = 1'b1;
        io.a_valid = 1'b0;
        io.b_valid = 1'b0;
        clear_model();
        repeat (n) tick();
        rst       = 1'b0;
        guard_end = cyc + c_L;
    endtask

    initial begin
        io.a_valid = 1'b0; io.a_rw = 1'b0; io.a_addr = '0; io.a_wdata = '0;
        io.b_valid = 1'b0; io.b_rw = 1'b0; io.b_addr = '0; io.b_wdata = '0;
        io.bus_rdata = '0; io.bus_rdata_valid = 1'b0;
        guard_end = 0;
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        clear_model();

        @(negedge clk);
        do_reset(3);
        chk("reset_bus_valid", io.bus_valid, 1'b0);
        chk("reset_flags", {io.resp_orphan, io.resp_lost}, 2'b00);
        repeat (c_L + 1) tick();

        // Single A read of 0x0003 returning 0xBEEF.
        mem[3] = 16'hBEEF;
        req_a(1'b0, 16'h0003, 16'h0000);
        tick();
        chk("t1_bus_valid", io.bus_valid, 1'b1);
        chk("t1_bus_addr",  io.bus_addr,  16'h0003);
        repeat (5) tick();
        chk("t1_a_rvalid", io.a_rvalid, 1'b1);
        chk("t1_a_rdata",  io.a_rdata,  16'hBEEF);
        chk("t1_b_rvalid", io.b_rvalid, 1'b0);
        repeat (3) tick();

        // Continuous contention: A reads, B writes 0x1234 to 0x0010.
        cnt_arv = 0;
        cnt_brv = 0;
        for (int k = 0; k < 8; k++) begin
            if (!io.a_valid) req_a(1'b0, 16'h0020 + 16'(k), 16'h0000);
            if (!io.b_valid) req_b(1'b1, 16'h0010, 16'h1234);
            #1;
            chk("t2_b_ready", io.b_ready, 32'(k % 2 == 0));
            chk("t2_a_ready", io.a_ready, 32'(k % 2 == 1));
            tick();
        end
        repeat (c_L + 4) tick();
        chk("t2_a_pulses", cnt_arv, 4);
        chk("t2_b_pulses", cnt_brv, 0);

        // A read then B read on consecutive cycles.
        mem[8'h40] = 16'h1111;
        mem[8'h41] = 16'h2222;
        req_a(1'b0, 16'h0040, 16'h0000);
        tick();
        req_b(1'b0, 16'h0041, 16'h0000);
        tick();
        repeat (c_L) tick();
        chk("t3_a_rvalid", io.a_rvalid, 1'b1);
        chk("t3_a_rdata",  io.a_rdata,  16'h1111);
        tick();
        chk("t3_b_rvalid", io.b_rvalid, 1'b1);
        chk("t3_b_rdata",  io.b_rdata,  16'h2222);
        chk("t3_a_quiet",  io.a_rvalid, 1'b0);
        repeat (3) tick();

        // Randomized traffic on both requesters.
        for (int i = 0; i < 300; i++) begin
            if (!io.a_valid && ($urandom_range(1, 0) == 1))
                req_a(1'($urandom_range(1, 0)), 16'($urandom), 16'($urandom));
            if (!io.b_valid && ($urandom_range(1, 0) == 1))
                req_b(1'($urandom_range(1, 0)), 16'($urandom), 16'($urandom));
            tick();
        end
        repeat (c_L + 6) tick();
        chk("rand_flags", {io.resp_orphan, io.resp_lost}, 2'b00);

        // Response with nothing outstanding.
        inject = 1'b1;
        tick();
        chk("t4_orphan_set", io.resp_orphan, 1'b1);
        chk("t4_no_rvalid", {io.a_rvalid, io.b_rvalid}, 2'b00);
        repeat (3) tick();
        chk("t4_orphan_sticky", io.resp_orphan, 1'b1);

        // Read whose response never comes back.
        drop_next = 1'b1;
        req_a(1'b0, 16'h0005, 16'h0000);
        tick();
        repeat (c_L + 1) tick();
        chk("t5_lost_set", io.resp_lost, 1'b1);
        chk("t5_no_rvalid", io.a_rvalid, 1'b0);
        repeat (2) tick();

        // Reset while a read is in flight; its late response must be dropped silently.
        req_a(1'b0, 16'h0006, 16'h0000);
        tick();
        tick();
        do_reset(1);
        cnt_arv = 0;
        repeat (8) tick();
        chk("t6_orphan_clear", io.resp_orphan, 1'b0);
        chk("t6_lost_clear",   io.resp_lost,   1'b0);
        chk("t6_no_pulse",     cnt_arv,        0);
        mem[7] = 16'h7777;
        req_a(1'b0, 16'h0007, 16'h0000);
        tick();
        repeat (c_L + 1) tick();
        chk("t6_a_rvalid", io.a_rvalid, 1'b1);
        chk("t6_a_rdata",  io.a_rdata,  16'h7777);
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
